// File: rtl/example_div_pkg.sv
// Shared definitions for the sequential 21s/7u restoring divider:
// state encoding, default operand widths and quotient saturation limits.
package example_div_pkg;

    localparam int DIVIDEND_W_DEF = 21;
    localparam int DIVISOR_W_DEF  = 7;
    localparam int QUOT_W_DEF     = 14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    // Largest / smallest value a signed quotient of width w can hold.
    function automatic int sat_hi(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/example_div_seq_step.sv
// One combinational restoring-division step.
// Ports: prem_i partial remainder, bit_i next dividend bit, dvs_i divisor;
//        prem_o next partial remainder, qbit_o quotient bit.
module example_div_seq_step #(
    parameter int W = 7
) (
    input  logic [W-1:0] prem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] prem_o,
    output logic         qbit_o
);

    logic [W:0] shifted;
    logic       ge;

    always_comb begin
        shifted = {prem_i, bit_i};
        ge      = (shifted >= {1'b0, dvs_i});
        qbit_o  = ge;
        // After a successful subtract the result is below the divisor,
        // so it always fits back into W bits.
        prem_o  = ge ? (shifted[W-1:0] - dvs_i) : shifted[W-1:0];
    end

endmodule

// File: rtl/example_div_seq_21s_7u.sv
// Sequential signed/unsigned divider (dividend 21s, divisor 7u), one
// quotient bit per cycle, with saturation and divide-by-zero flagging.
// Ports: ap_clk, ap_rst_n (async, active-low); in_valid/in_ready with
//        din0 (signed dividend), din1 (unsigned divisor); out_valid/out_ready
//        with dout (signed quotient), rem (signed remainder), ovf, dbz.
module example_div_seq_21s_7u
    import example_div_pkg::*;
#(
    parameter logic [31:0] ID         = 32'd1,
    parameter int          DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int          DIVISOR_W  = DIVISOR_W_DEF,
    parameter int          QUOT_W     = QUOT_W_DEF
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     dout,
    output logic [DIVISOR_W:0]    rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int WQ    = DIVIDEND_W + 1;
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    localparam logic signed [WQ-1:0]  Q_HI = WQ'(sat_hi(QUOT_W));
    localparam logic signed [WQ-1:0]  Q_LO = WQ'(sat_lo(QUOT_W));
    localparam logic [CNT_W-1:0]      LAST = CNT_W'(DIVIDEND_W - 1);

    div_state_e state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  fix_ph_q, fix_ph_d;
    logic                  neg_q, neg_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  prem_q, prem_d;
    logic [WQ-1:0]         qs_q, qs_d;
    logic [DIVISOR_W:0]    rs_q, rs_d;
    logic [QUOT_W-1:0]     dout_q, dout_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic                  ovf_q, ovf_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W-1:0]  step_prem;
    logic                  step_qbit;

    // quo_q starts as |dividend| and is shifted left each step; freed
    // LSBs collect quotient bits, so it ends holding |quotient|.
    example_div_seq_step #(
        .W(DIVISOR_W)
    ) u_step (
        .prem_i(prem_q),
        .bit_i (quo_q[DIVIDEND_W-1]),
        .dvs_i (dvs_q),
        .prem_o(step_prem),
        .qbit_o(step_qbit)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fix_ph_q <= 1'b0;
            neg_q    <= 1'b0;
            dvs_q    <= '0;
            quo_q    <= '0;
            prem_q   <= '0;
            qs_q     <= '0;
            rs_q     <= '0;
            dout_q   <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fix_ph_q <= fix_ph_d;
            neg_q    <= neg_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            prem_q   <= prem_d;
            qs_q     <= qs_d;
            rs_q     <= rs_d;
            dout_q   <= dout_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fix_ph_d = fix_ph_q;
        neg_d    = neg_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        prem_d   = prem_q;
        qs_d     = qs_q;
        rs_d     = rs_q;
        dout_d   = dout_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_CALC;
                    neg_d   = din0[DIVIDEND_W-1];
                    // -(-2^20) wraps to 2^20, which is correct unsigned.
                    quo_d   = din0[DIVIDEND_W-1] ? -din0 : din0;
                    dvs_d   = din1;
                    prem_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_CALC: begin
                quo_d  = {quo_q[DIVIDEND_W-2:0], step_qbit};
                prem_d = step_prem;
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    fix_ph_d = 1'b0;
                    state_d  = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                // Phase 0 applies the dividend sign; phase 1 saturates
                // and loads the output registers.
                if (!fix_ph_q) begin
                    fix_ph_d = 1'b1;
                    qs_d = neg_q ? -{1'b0, quo_q} : {1'b0, quo_q};
                    rs_d = neg_q ? -{1'b0, prem_q} : {1'b0, prem_q};
                end else begin
                    fix_ph_d = 1'b0;
                    state_d  = S_DONE;
                    dbz_d    = 1'b0;
                    ovf_d    = 1'b0;
                    rem_d    = rs_q;
                    dout_d   = qs_q[QUOT_W-1:0];
                    if (dvs_q == '0) begin
                        dbz_d  = 1'b1;
                        ovf_d  = 1'b1;
                        rem_d  = '0;
                        dout_d = neg_q ? Q_LO[QUOT_W-1:0]
                                       : Q_HI[QUOT_W-1:0];
                    end else if ($signed(qs_q) > Q_HI) begin
                        ovf_d  = 1'b1;
                        dout_d = Q_HI[QUOT_W-1:0];
                    end else if ($signed(qs_q) < Q_LO) begin
                        ovf_d  = 1'b1;
                        dout_d = Q_LO[QUOT_W-1:0];
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign dout      = dout_q;
    assign rem       = rem_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule
